// File: rtl/memxfer_pkg.sv
// memxfer_pkg: shared types and limits for the memxfer transfer engine.
package memxfer_pkg;

  localparam int MAX_SRC_LATENCY = 7;

  typedef enum logic [1:0] {
    XFER_FWD  = 2'b00,
    XFER_REV  = 2'b01,
    XFER_FILL = 2'b10,
    XFER_RSVD = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/memxfer_if.sv
// memxfer_if: command/status and RAM port bundle of the memxfer engine.
//
// Handshake: the requester raises activate; it is taken only while busy is
// low (engine idle). busy rises the cycle after acceptance and stays high
// until the cycle after the one-cycle done pulse; aborted and err are only
// meaningful while done is high. abort is honoured only while a transfer is
// moving data. The RAM side has no back-pressure: a read issued with
// ram_rd_ena returns data a fixed latency later, a write with ram_wr_ena
// lands at the next clock edge.
interface memxfer_if #(
  parameter int MEM_WIDTH   = 8,
  parameter int SRC_ADDR_SZ = 14,
  parameter int DST_ADDR_SZ = 14
);
  logic                   activate;
  logic [1:0]             mode;
  logic [SRC_ADDR_SZ-1:0] src_addr;
  logic [DST_ADDR_SZ-1:0] dst_addr;
  logic [SRC_ADDR_SZ-1:0] len;
  logic [MEM_WIDTH-1:0]   fill_data;
  logic                   abort;
  logic                   busy;
  logic                   done;
  logic                   aborted;
  logic                   err;
  logic                   clk_ram_rd;
  logic                   ram_rd_ena;
  logic [SRC_ADDR_SZ-1:0] ram_rd_addr;
  logic [MEM_WIDTH-1:0]   ram_rd_data;
  logic                   clk_ram_wr;
  logic                   ram_wr_ena;
  logic [DST_ADDR_SZ-1:0] ram_wr_addr;
  logic [MEM_WIDTH-1:0]   ram_wr_data;

  modport master (
    input  activate, mode, src_addr, dst_addr, len, fill_data, abort, ram_rd_data,
    output busy, done, aborted, err, clk_ram_rd, ram_rd_ena, ram_rd_addr,
           clk_ram_wr, ram_wr_ena, ram_wr_addr, ram_wr_data
  );

  modport slave (
    output activate, mode, src_addr, dst_addr, len, fill_data, abort, ram_rd_data,
    input  busy, done, aborted, err, clk_ram_rd, ram_rd_ena, ram_rd_addr,
           clk_ram_wr, ram_wr_ena, ram_wr_addr, ram_wr_data
  );
endinterface

// File: rtl/memxfer_rd_pipe.sv
// memxfer_rd_pipe: DEPTH-stage valid shift register that follows each issued
// source read until its data appears on the RAM read port.
module memxfer_rd_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic in_valid,
  output logic valid_out,
  output logic empty
);

  logic [DEPTH-1:0] v;

  // Shift one stage per clock; flush drops every read still in flight.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      v <= '0;
    end else begin
      v[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        v[i] <= v[i-1];
      end
    end
  end

  assign valid_out = v[DEPTH-1];
  assign empty     = ~|v;

endmodule

// File: rtl/memxfer.sv
// memxfer: single-channel memory transfer engine (forward copy, reverse copy,
// constant fill) with abort and a one-cycle done pulse.
// Optional build macro MEMXFER_CHECKSUM_EN adds a `checksum` output holding the
// XOR of all words written by the current transfer.
module memxfer
  import memxfer_pkg::*;
#(
  parameter int MEM_WIDTH   = 8,
  parameter int SRC_ADDR_SZ = 14,
  parameter int DST_ADDR_SZ = 14,
  parameter int SRC_LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  memxfer_if.master        bus,
  output state_t           dbg_state
`ifdef MEMXFER_CHECKSUM_EN
  ,
  output logic [MEM_WIDTH-1:0] checksum
`endif
);

  // Out-of-range latencies are clamped so the valid pipe always has 1..7 stages.
  localparam int PIPE_DEPTH = (SRC_LATENCY > MAX_SRC_LATENCY) ? MAX_SRC_LATENCY :
                              (SRC_LATENCY < 1) ? 1 : SRC_LATENCY;
  localparam logic [SRC_ADDR_SZ-1:0] SRC_ONE = 1;
  localparam logic [DST_ADDR_SZ-1:0] DST_ONE = 1;

  state_t                 state, state_next;
  mode_t                  mode_q, mode_in;
  logic [SRC_ADDR_SZ-1:0] cnt, rd_ptr;
  logic [DST_ADDR_SZ-1:0] dst_ptr, wr_addr_q, len_dst;
  logic [MEM_WIDTH-1:0]   wr_data_q;
  logic                   wr_ena_q, aborted_q, err_q;
  logic                   accept, degenerate, abort_take, last_issue;
  logic                   is_fill, is_rev, rd_issue, pipe_valid, pipe_empty;

  assign mode_in    = mode_t'(bus.mode);
  assign len_dst    = DST_ADDR_SZ'(bus.len);
  assign accept     = (state == S_IDLE) && bus.activate;
  assign degenerate = (bus.len == '0) || (mode_in == XFER_RSVD);
  assign abort_take = bus.abort && ((state == S_ISSUE) || (state == S_DRAIN));
  assign last_issue = (cnt == SRC_ONE);
  assign is_fill    = (mode_q == XFER_FILL);
  assign is_rev     = (mode_q == XFER_REV);
  assign rd_issue   = (state == S_ISSUE) && !is_fill;

  memxfer_rd_pipe #(.DEPTH(PIPE_DEPTH)) u_rd_pipe (
    .clk       (clk),
    .reset     (reset),
    .flush     (abort_take),
    .in_valid  (rd_issue),
    .valid_out (pipe_valid),
    .empty     (pipe_empty)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic. Degenerate requests spend one cycle in S_DRAIN with an
  // empty pipe so their done pulse lands two cycles after acceptance.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = degenerate ? S_DRAIN : S_ISSUE;
      S_ISSUE: begin
        if (abort_take)      state_next = S_DONE;
        else if (last_issue) state_next = is_fill ? S_DONE : S_DRAIN;
      end
      S_DRAIN: if (abort_take || pipe_empty) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Transfer datapath: latches the request, walks the source and destination
  // pointers and registers every write one cycle before it reaches the RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q    <= XFER_FWD;
      cnt       <= '0;
      rd_ptr    <= '0;
      dst_ptr   <= '0;
      wr_ena_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_ena_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            mode_q    <= mode_in;
            err_q     <= (mode_in == XFER_RSVD);
            aborted_q <= 1'b0;
            cnt       <= bus.len;
            rd_ptr    <= (mode_in == XFER_REV) ? bus.src_addr + bus.len - SRC_ONE : bus.src_addr;
            dst_ptr   <= (mode_in == XFER_REV) ? bus.dst_addr + len_dst - DST_ONE : bus.dst_addr;
            // Fill needs its first write in the very next cycle.
            if ((mode_in == XFER_FILL) && (bus.len != '0)) begin
              wr_ena_q  <= 1'b1;
              wr_addr_q <= bus.dst_addr;
              wr_data_q <= bus.fill_data;
              dst_ptr   <= bus.dst_addr + DST_ONE;
            end
          end
        end
        S_ISSUE: begin
          if (abort_take) begin
            aborted_q <= 1'b1;
          end else begin
            cnt <= cnt - SRC_ONE;
            if (is_fill) begin
              if (!last_issue) begin
                wr_ena_q  <= 1'b1;
                wr_addr_q <= dst_ptr;
                dst_ptr   <= dst_ptr + DST_ONE;
              end
            end else begin
              rd_ptr <= is_rev ? rd_ptr - SRC_ONE : rd_ptr + SRC_ONE;
            end
          end
        end
        S_DRAIN: if (abort_take) aborted_q <= 1'b1;
        default: ;
      endcase
      // Copy modes: read data arriving from the RAM becomes the next write.
      if (pipe_valid && !abort_take) begin
        wr_ena_q  <= 1'b1;
        wr_addr_q <= dst_ptr;
        wr_data_q <= bus.ram_rd_data;
        dst_ptr   <= is_rev ? dst_ptr - DST_ONE : dst_ptr + DST_ONE;
      end
    end
  end

`ifdef MEMXFER_CHECKSUM_EN
  logic [MEM_WIDTH-1:0] chk_q;

  // Running XOR of words as they are written; held after done until next accept.
  always_ff @(posedge clk) begin
    if (reset || accept) chk_q <= '0;
    else if (wr_ena_q)   chk_q <= chk_q ^ wr_data_q;
  end

  assign checksum = chk_q;
`endif

  assign dbg_state       = state;
  assign bus.busy        = reset || (state != S_IDLE);
  assign bus.done        = (state == S_DONE) && !reset;
  assign bus.aborted     = bus.done && aborted_q;
  assign bus.err         = bus.done && err_q;
  assign bus.clk_ram_rd  = clk;
  assign bus.clk_ram_wr  = clk;
  assign bus.ram_rd_ena  = rd_issue;
  assign bus.ram_rd_addr = rd_ptr;
  assign bus.ram_wr_ena  = wr_ena_q;
  assign bus.ram_wr_addr = wr_addr_q;
  assign bus.ram_wr_data = wr_data_q;

endmodule

// File: tb/tb_memxfer.sv
// tb_memxfer: directed bench for memxfer. Two engines share one RAM model:
// u_dut_a with read latency 2, u_dut_b with read latency 3.
module tb_memxfer;
  import memxfer_pkg::*;

  localparam int MW = 8;
  localparam int SA = 14;
  localparam int DA = 14;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUTs and shared RAM ----------------
  memxfer_if #(.MEM_WIDTH(MW), .SRC_ADDR_SZ(SA), .DST_ADDR_SZ(DA)) bus_a ();
  memxfer_if #(.MEM_WIDTH(MW), .SRC_ADDR_SZ(SA), .DST_ADDR_SZ(DA)) bus_b ();

  state_t state_a, state_b;
  logic [MW-1:0] chk_a, chk_b;

  memxfer #(.MEM_WIDTH(MW), .SRC_ADDR_SZ(SA), .DST_ADDR_SZ(DA), .SRC_LATENCY(2)) u_dut_a (
    .clk(clk), .reset(rst), .bus(bus_a), .dbg_state(state_a)
`ifdef MEMXFER_CHECKSUM_EN
    , .checksum(chk_a)
`endif
  );

  memxfer #(.MEM_WIDTH(MW), .SRC_ADDR_SZ(SA), .DST_ADDR_SZ(DA), .SRC_LATENCY(3)) u_dut_b (
    .clk(clk), .reset(rst), .bus(bus_b), .dbg_state(state_b)
`ifdef MEMXFER_CHECKSUM_EN
    , .checksum(chk_b)
`endif
  );

`ifndef MEMXFER_CHECKSUM_EN
  assign chk_a = '0;
  assign chk_b = '0;
`endif

  logic          sel, act, abort;
  logic [1:0]    mode;
  logic [SA-1:0] src, len;
  logic [DA-1:0] dst;
  logic [MW-1:0] fill;

  assign bus_a.activate  = act & ~sel;
  assign bus_b.activate  = act & sel;
  assign bus_a.mode      = mode;      assign bus_b.mode      = mode;
  assign bus_a.src_addr  = src;       assign bus_b.src_addr  = src;
  assign bus_a.dst_addr  = dst;       assign bus_b.dst_addr  = dst;
  assign bus_a.len       = len;       assign bus_b.len       = len;
  assign bus_a.fill_data = fill;      assign bus_b.fill_data = fill;
  assign bus_a.abort     = abort;     assign bus_b.abort     = abort;

  function automatic logic [7:0] pat(input int a);
    return 8'((a * 37 + 11) ^ (a >> 6));
  endfunction

  logic [7:0] mem [0:16383];
  logic [7:0] pa [0:1];
  logic [7:0] pb [0:2];
  logic       mem_init;

  // RAM model: fixed-latency read pipes per engine, writes land at the edge.
  always @(posedge clk) begin
    pa[0] <= bus_a.ram_rd_ena ? mem[bus_a.ram_rd_addr] : 8'h00;
    pa[1] <= pa[0];
    pb[0] <= bus_b.ram_rd_ena ? mem[bus_b.ram_rd_addr] : 8'h00;
    pb[1] <= pb[0];
    pb[2] <= pb[1];
    if (mem_init) for (int i = 0; i < 16384; i++) mem[i] = pat(i);
    if (bus_a.ram_wr_ena) mem[bus_a.ram_wr_addr] = bus_a.ram_wr_data;
    if (bus_b.ram_wr_ena) mem[bus_b.ram_wr_addr] = bus_b.ram_wr_data;
  end
  assign bus_a.ram_rd_data = pa[1];
  assign bus_b.ram_rd_data = pb[2];

  logic          o_busy, o_done, o_aborted, o_err, o_rd_ena, o_wr_ena;
  logic [SA-1:0] o_rd_addr;
  logic [DA-1:0] o_wr_addr;
  logic [MW-1:0] o_wr_data, o_chk;
  assign o_busy    = sel ? bus_b.busy        : bus_a.busy;
  assign o_done    = sel ? bus_b.done        : bus_a.done;
  assign o_aborted = sel ? bus_b.aborted     : bus_a.aborted;
  assign o_err     = sel ? bus_b.err         : bus_a.err;
  assign o_rd_ena  = sel ? bus_b.ram_rd_ena  : bus_a.ram_rd_ena;
  assign o_rd_addr = sel ? bus_b.ram_rd_addr : bus_a.ram_rd_addr;
  assign o_wr_ena  = sel ? bus_b.ram_wr_ena  : bus_a.ram_wr_ena;
  assign o_wr_addr = sel ? bus_b.ram_wr_addr : bus_a.ram_wr_addr;
  assign o_wr_data = sel ? bus_b.ram_wr_data : bus_a.ram_wr_data;
  assign o_chk     = sel ? chk_b             : chk_a;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [SA+MW-1:0] exp_q[$];
  logic [MW-1:0]    exp_chk;
  int               exp_n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_wr(input int addr, input logic [7:0] data);
    exp_q.push_back({14'(addr), data});
    exp_chk ^= data;
  endtask

  task automatic new_test();
    exp_q.delete();
    exp_chk = '0;
  endtask

  // ---------------- driver / monitor ----------------
  int   first_rd, first_rd_addr, rd_cnt, first_wr, last_wr, wr_cnt, done_cyc, busy_after;
  logic done_abt, done_err;
  logic [MW-1:0] done_chk;

  // Cycle 0 is the cycle in which activate is sampled.
  task automatic run(input logic use_b, input logic [1:0] m, input int s, input int d,
                     input int n, input logic [7:0] f, input int abort_at,
                     input int reset_at, input int budget);
    logic [SA+MW-1:0] e;
    first_rd = -1; first_rd_addr = -1; rd_cnt = 0; first_wr = -1; last_wr = -1;
    wr_cnt = 0; done_cyc = -1; busy_after = -1; done_abt = 0; done_err = 0; done_chk = '0;
    exp_n = exp_q.size();
    @(posedge clk); #1;
    sel = use_b; mode = m; src = 14'(s); dst = 14'(d); len = 14'(n); fill = f;
    abort = 0; act = 1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (o_rd_ena) begin
        rd_cnt++;
        if (first_rd < 0) begin first_rd = c; first_rd_addr = int'(o_rd_addr); end
      end
      if (o_wr_ena) begin
        wr_cnt++;
        if (first_wr < 0) first_wr = c;
        last_wr = c;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("wr_addr_data", 32'({o_wr_addr, o_wr_data}), 32'(e));
        end
      end
      if (done_cyc >= 0) begin
        busy_after = int'(o_busy);
        break;
      end
      if (o_done) begin
        done_cyc = c; done_abt = o_aborted; done_err = o_err; done_chk = o_chk;
      end
      @(posedge clk); #1;
      act = 0;
      abort = (c + 1 == abort_at);
      rst = (c + 1 == reset_at);
    end
    abort = 0; rst = 0;
    check("wr_cnt", wr_cnt, exp_n);
  endtask

  task automatic check_done(input int exp_done, input logic exp_abt, input logic exp_err);
    check("done_cycle", done_cyc, exp_done);
    check("aborted", done_abt, exp_abt);
    check("err", done_err, exp_err);
    check("busy_after_done", busy_after, 0);
`ifdef MEMXFER_CHECKSUM_EN
    check("checksum", done_chk, exp_chk);
`endif
  endtask

  // ---------------- main sequence ----------------
  initial begin
    sel = 0; act = 0; abort = 0; mode = 0; src = 0; dst = 0; len = 0; fill = 0;
    mem_init = 1;
    exp_chk = '0;
    repeat (2) @(posedge clk);
    #1 mem_init = 0;
    @(negedge clk);
    check("busy_in_reset", o_busy, 1);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_rd_ena", o_rd_ena, 0);
    check("rst_wr_ena", o_wr_ena, 0);
    check("rst_state", state_a, S_IDLE);
    check("rst_chk", o_chk, 0);

    // Forward copy 0x010 -> 0x200, 4 words.
    new_test();
    for (int i = 0; i < 4; i++) push_wr(16'h200 + i, pat(16'h010 + i));
    run(0, 2'b00, 16'h010, 16'h200, 4, 8'h00, -1, -1, 40);
    check("fwd_first_rd", first_rd, 1);
    check("fwd_first_rd_addr", first_rd_addr, 16'h010);
    check("fwd_rd_cnt", rd_cnt, 4);
    check("fwd_first_wr", first_wr, 4);
    check("fwd_last_wr", last_wr, 7);
    check_done(8, 0, 0);

    // Reverse overlapping copy 0x100 -> 0x102, 8 words, shared RAM.
    new_test();
    for (int i = 7; i >= 0; i--) push_wr(16'h102 + i, pat(16'h100 + i));
    run(0, 2'b01, 16'h100, 16'h102, 8, 8'h00, -1, -1, 40);
    check("rev_first_rd_addr", first_rd_addr, 16'h107);
    check("rev_rd_cnt", rd_cnt, 8);
    check("rev_first_wr", first_wr, 4);
    check_done(12, 0, 0);
    for (int i = 0; i < 8; i++) check("rev_mem", mem[16'h102 + i], pat(16'h100 + i));

    // Fill with wrap-around at the top of the destination space.
    new_test();
    push_wr(16'h3FFE, 8'hA5); push_wr(16'h3FFF, 8'hA5);
    push_wr(16'h0000, 8'hA5); push_wr(16'h0001, 8'hA5);
    run(0, 2'b10, 0, 16'h3FFE, 4, 8'hA5, -1, -1, 40);
    check("fill_rd_cnt", rd_cnt, 0);
    check("fill_first_wr", first_wr, 1);
    check_done(5, 0, 0);

    // len = 0 and reserved mode: no RAM activity, done at cycle 2.
    new_test();
    run(0, 2'b00, 16'h050, 16'h600, 0, 8'h00, -1, -1, 40);
    check("len0_rd_cnt", rd_cnt, 0);
    check_done(2, 0, 0);
    new_test();
    run(0, 2'b11, 16'h050, 16'h600, 5, 8'h00, -1, -1, 40);
    check("rsvd_rd_cnt", rd_cnt, 0);
    check_done(2, 0, 1);

    // Abort at cycle 6 of a 16-word forward copy: writes at 4,5,6 only.
    new_test();
    for (int i = 0; i < 3; i++) push_wr(16'h300 + i, pat(16'h020 + i));
    run(0, 2'b00, 16'h020, 16'h300, 16, 8'h00, 6, -1, 60);
    check("abort_rd_cnt", rd_cnt, 6);
    check("abort_last_wr", last_wr, 6);
    check_done(7, 1, 0);

    // Latency-3 engine: reset at cycle 5 abandons the transfer; only the
    // write already registered for cycle 5 reaches the RAM.
    new_test();
    push_wr(16'h500, pat(16'h040));
    run(1, 2'b00, 16'h040, 16'h500, 8, 8'h00, -1, 5, 30);
    check("rst_mid_done", done_cyc, -1);
    check("rst_mid_last_wr", last_wr, 5);
    check("rst_mid_state", state_b, S_IDLE);

    // Rerun on the latency-3 engine with a single word.
    new_test();
    push_wr(16'h510, pat(16'h041));
    run(1, 2'b00, 16'h041, 16'h510, 1, 8'h00, -1, -1, 30);
    check("lat3_first_wr", first_wr, 5);
    check_done(6, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
